// File: rtl/vit_dec_trb_outmap_if.sv
// vit_dec_trb_outmap_if: traceback LIFO step stream in, mapped output and frame statistics out
//   ival/isop/ieop/itag/idat/ibiterr : popped LIFO step (driven by master)
//   oval/osop/oeop/otag/odat         : registered output step (driven by slave)
//   obiterr/oerrcnt                  : per-step and running frame error counts
//   ofval/ofabort/ofsymb/oferrcnt    : per-frame statistics strobe and values
//   odrop                            : step arrived outside a frame
interface vit_dec_trb_outmap_if #(
    parameter int pDAT_W      = 3,
    parameter int pHD_W       = 4,
    parameter int pERR_CNT_W  = 16,
    parameter int pSYMB_CNT_W = 16,
    parameter int pTAG_W      = 4
);
    localparam int cBE_W = $clog2(pHD_W + 1);
    logic                   ival;
    logic                   isop;
    logic                   ieop;
    logic [pTAG_W-1:0]      itag;
    logic [pDAT_W-1:0]      idat;
    logic [pHD_W-1:0]       ibiterr;
    logic                   oval;
    logic                   osop;
    logic                   oeop;
    logic [pTAG_W-1:0]      otag;
    logic [pDAT_W-1:0]      odat;
    logic [cBE_W-1:0]       obiterr;
    logic [pERR_CNT_W-1:0]  oerrcnt;
    logic                   ofval;
    logic                   ofabort;
    logic [pSYMB_CNT_W-1:0] ofsymb;
    logic [pERR_CNT_W-1:0]  oferrcnt;
    logic                   odrop;
    modport master (
        output ival, isop, ieop, itag, idat, ibiterr,
        input  oval, osop, oeop, otag, odat, obiterr, oerrcnt,
        input  ofval, ofabort, ofsymb, oferrcnt, odrop
    );
    modport slave (
        input  ival, isop, ieop, itag, idat, ibiterr,
        output oval, osop, oeop, otag, odat, obiterr, oerrcnt,
        output ofval, ofabort, ofsymb, oferrcnt, odrop
    );
endinterface

// File: rtl/vit_dec_trb_outmap.sv
// vit_dec_trb_outmap: Viterbi traceback output mapper with error counting and frame statistics
//   iclk     : clock
//   ireset_n : asynchronous active-low reset
//   iclkena  : clock enable, all state frozen when low
//   bus      : step stream in / mapped stream and frame statistics out (slave side)
module vit_dec_trb_outmap #(
    parameter int pDAT_W      = 3,
    parameter int pHD_W       = 4,
    parameter int pERR_CNT_W  = 16,
    parameter int pSYMB_CNT_W = 16,
    parameter int pTAG_W      = 4
) (
    input logic                  iclk,
    input logic                  ireset_n,
    input logic                  iclkena,
    vit_dec_trb_outmap_if.slave  bus
);
    localparam int cBE_W = $clog2(pHD_W + 1);
    typedef enum logic {IDLE, FRAME} state_t;
    state_t                 state;
    logic [cBE_W-1:0]       pc;
    logic [pERR_CNT_W:0]    esum;
    logic [pERR_CNT_W-1:0]  esat;
    logic [pSYMB_CNT_W-1:0] cnt;
    logic [pSYMB_CNT_W-1:0] cnt_inc;
    always_comb begin
        pc = '0;
        for (int i = 0; i < pHD_W; i++) pc = pc + cBE_W'(bus.ibiterr[i]);
    end
    // one extra bit catches the carry so the running count clamps instead of wrapping
    assign esum    = {1'b0, bus.oerrcnt} + (pERR_CNT_W + 1)'(pc);
    assign esat    = esum[pERR_CNT_W] ? '1 : esum[pERR_CNT_W-1:0];
    assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.oval     <= 1'b0;
            bus.osop     <= 1'b0;
            bus.oeop     <= 1'b0;
            bus.otag     <= '0;
            bus.odat     <= '0;
            bus.obiterr  <= '0;
            bus.oerrcnt  <= '0;
            bus.ofval    <= 1'b0;
            bus.ofabort  <= 1'b0;
            bus.ofsymb   <= '0;
            bus.oferrcnt <= '0;
            bus.odrop    <= 1'b0;
        end else if (iclkena) begin
            bus.oval  <= 1'b0;
            bus.osop  <= 1'b0;
            bus.oeop  <= 1'b0;
            bus.ofval <= 1'b0;
            bus.odrop <= 1'b0;
            if (bus.ival && bus.isop) begin
                bus.oval    <= 1'b1;
                bus.osop    <= 1'b1;
                bus.oeop    <= bus.ieop;
                bus.otag    <= bus.itag;
                bus.odat    <= bus.idat;
                bus.obiterr <= pc;
                bus.oerrcnt <= pERR_CNT_W'(pc);
                cnt         <= pSYMB_CNT_W'(1);
                state       <= bus.ieop ? IDLE : FRAME;
                // a sop inside a frame closes the old frame as aborted; that report wins the strobe
                if (state == FRAME) begin
                    bus.ofval    <= 1'b1;
                    bus.ofabort  <= 1'b1;
                    bus.ofsymb   <= cnt;
                    bus.oferrcnt <= bus.oerrcnt;
                end else if (bus.ieop) begin
                    bus.ofval    <= 1'b1;
                    bus.ofabort  <= 1'b0;
                    bus.ofsymb   <= pSYMB_CNT_W'(1);
                    bus.oferrcnt <= pERR_CNT_W'(pc);
                end
            end else if (bus.ival && state == FRAME) begin
                bus.oval    <= 1'b1;
                bus.oeop    <= bus.ieop;
                bus.odat    <= bus.idat;
                bus.obiterr <= pc;
                bus.oerrcnt <= esat;
                cnt         <= cnt_inc;
                if (bus.ieop) begin
                    bus.ofval    <= 1'b1;
                    bus.ofabort  <= 1'b0;
                    bus.ofsymb   <= cnt_inc;
                    bus.oferrcnt <= esat;
                    state        <= IDLE;
                end
            end else if (bus.ival) begin
                bus.odrop <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_vit_dec_trb_outmap.sv
// tb_vit_dec_trb_outmap: directed bench for the traceback output mapper
module tb_vit_dec_trb_outmap;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    int total = 0;
    int bad = 0;
    vit_dec_trb_outmap_if #(.pDAT_W(3), .pHD_W(4), .pERR_CNT_W(4), .pSYMB_CNT_W(16), .pTAG_W(4)) bus ();
    vit_dec_trb_outmap #(.pDAT_W(3), .pHD_W(4), .pERR_CNT_W(4), .pSYMB_CNT_W(16), .pTAG_W(4)) dut (
        .iclk(clk),
        .ireset_n(rst_n),
        .iclkena(ena),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic s, input logic e, input logic [3:0] tag,
                         input logic [2:0] dat, input logic [3:0] be);
        @(negedge clk);
        bus.ival = v;
        bus.isop = s;
        bus.ieop = e;
        bus.itag = tag;
        bus.idat = dat;
        bus.ibiterr = be;
        @(posedge clk);
        #1;
    endtask

    // flags packed as {oval, osop, oeop, ofval, ofabort, odrop}
    task automatic test_reset;
        bus.ival = 1'b0; bus.isop = 1'b0; bus.ieop = 1'b0;
        bus.itag = '0; bus.idat = '0; bus.ibiterr = '0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.oval, bus.osop, bus.oeop, bus.ofval, bus.ofabort, bus.odrop} !== 6'b0) begin
            bad++; $display("FAIL reset_flags got=%b exp=000000", {bus.oval, bus.osop, bus.oeop, bus.ofval, bus.ofabort, bus.odrop});
        end
        total++;
        if ({bus.otag, bus.odat, bus.obiterr, bus.oerrcnt, bus.ofsymb, bus.oferrcnt} !== '0) begin
            bad++; $display("FAIL reset_values not all zero errcnt=%0d ofsymb=%0d", bus.oerrcnt, bus.ofsymb);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_frame8;
        logic [3:0] be [8] = '{4'b0000, 4'b1011, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, i == 7, 4'd7, 3'(i), be[i]);
            if (i == 0) begin
                total++;
                if ({bus.oval, bus.osop, bus.ofval, bus.otag} !== {3'b110, 4'd7}) begin
                    bad++; $display("FAIL f8_sop got=%b tag=%0d exp=110 tag=7", {bus.oval, bus.osop, bus.ofval}, bus.otag);
                end
            end
            if (i == 1) begin
                total++;
                if ({bus.obiterr, bus.oerrcnt} !== {3'd3, 4'd3}) begin
                    bad++; $display("FAIL f8_step2 obiterr=%0d oerrcnt=%0d exp=3 3", bus.obiterr, bus.oerrcnt);
                end
            end
            if (i == 4) begin
                total++;
                if ({bus.obiterr, bus.oerrcnt, bus.odat} !== {3'd1, 4'd4, 3'd4}) begin
                    bad++; $display("FAIL f8_step5 obiterr=%0d oerrcnt=%0d odat=%0d exp=1 4 4", bus.obiterr, bus.oerrcnt, bus.odat);
                end
            end
            if (i == 6) begin
                total++;
                if ({bus.oval, bus.oeop, bus.ofval} !== 3'b100) begin
                    bad++; $display("FAIL f8_step7 got=%b exp=100", {bus.oval, bus.oeop, bus.ofval});
                end
            end
        end
        total++;
        if ({bus.oval, bus.oeop, bus.ofval, bus.ofabort} !== 4'b1110 || bus.ofsymb !== 16'd8 || bus.oferrcnt !== 4'd4) begin
            bad++; $display("FAIL f8_eop flags=%b ofsymb=%0d oferrcnt=%0d exp=1110 8 4",
                            {bus.oval, bus.oeop, bus.ofval, bus.ofabort}, bus.ofsymb, bus.oferrcnt);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 4'b1111);
        total++;
        if ({bus.oval, bus.ofval} !== 2'b00 || bus.ofsymb !== 16'd8 || bus.oerrcnt !== 4'd4 || bus.obiterr !== 3'd0 || bus.otag !== 4'd7) begin
            bad++; $display("FAIL f8_idle_hold oval=%b ofval=%b ofsymb=%0d oerrcnt=%0d obiterr=%0d otag=%0d exp=0 0 8 4 0 7",
                            bus.oval, bus.ofval, bus.ofsymb, bus.oerrcnt, bus.obiterr, bus.otag);
        end
    endtask

    task automatic test_single;
        drive(1'b1, 1'b1, 1'b1, 4'd5, 3'd2, 4'b1111);
        total++;
        if ({bus.oval, bus.osop, bus.oeop, bus.ofval, bus.ofabort, bus.odrop} !== 6'b111100) begin
            bad++; $display("FAIL single_flags got=%b exp=111100", {bus.oval, bus.osop, bus.oeop, bus.ofval, bus.ofabort, bus.odrop});
        end
        total++;
        if ({bus.otag, bus.obiterr, bus.oerrcnt, bus.oferrcnt} !== {4'd5, 3'd4, 4'd4, 4'd4} || bus.ofsymb !== 16'd1) begin
            bad++; $display("FAIL single_vals otag=%0d obiterr=%0d oerrcnt=%0d oferrcnt=%0d ofsymb=%0d exp=5 4 4 4 1",
                            bus.otag, bus.obiterr, bus.oerrcnt, bus.oferrcnt, bus.ofsymb);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 4'b0000);
    endtask

    task automatic test_abort;
        for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'b0, 4'd1, 3'd1, 4'b0001);
        total++;
        if ({bus.ofval, bus.oerrcnt, bus.otag} !== {1'b0, 4'd3, 4'd1}) begin
            bad++; $display("FAIL abort_a ofval=%b oerrcnt=%0d otag=%0d exp=0 3 1", bus.ofval, bus.oerrcnt, bus.otag);
        end
        drive(1'b1, 1'b1, 1'b0, 4'd2, 3'd6, 4'b0110);
        total++;
        if ({bus.oval, bus.osop, bus.ofval, bus.ofabort} !== 4'b1111 || bus.ofsymb !== 16'd3 || bus.oferrcnt !== 4'd3) begin
            bad++; $display("FAIL abort_stats flags=%b ofsymb=%0d oferrcnt=%0d exp=1111 3 3",
                            {bus.oval, bus.osop, bus.ofval, bus.ofabort}, bus.ofsymb, bus.oferrcnt);
        end
        total++;
        if ({bus.otag, bus.oerrcnt, bus.odat} !== {4'd2, 4'd2, 3'd6}) begin
            bad++; $display("FAIL abort_newframe otag=%0d oerrcnt=%0d odat=%0d exp=2 2 6", bus.otag, bus.oerrcnt, bus.odat);
        end
        drive(1'b1, 1'b0, 1'b1, 4'd9, 3'd0, 4'b0000);
        total++;
        if ({bus.oeop, bus.ofval, bus.ofabort, bus.otag, bus.oferrcnt} !== {3'b110, 4'd2, 4'd2} || bus.ofsymb !== 16'd2) begin
            bad++; $display("FAIL abort_b_eop flags=%b otag=%0d oferrcnt=%0d ofsymb=%0d exp=110 2 2 2",
                            {bus.oeop, bus.ofval, bus.ofabort}, bus.otag, bus.oferrcnt, bus.ofsymb);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 4'b0000);
    endtask

    task automatic test_saturate;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, i == 0, i == 9, 4'd4, 3'd3, 4'b0011);
            if (i == 6) begin
                total++;
                if (bus.oerrcnt !== 4'd14) begin
                    bad++; $display("FAIL sat_step7 oerrcnt=%0d exp=14", bus.oerrcnt);
                end
            end
            if (i == 7) begin
                total++;
                if (bus.oerrcnt !== 4'd15) begin
                    bad++; $display("FAIL sat_step8 oerrcnt=%0d exp=15", bus.oerrcnt);
                end
            end
        end
        total++;
        if ({bus.oerrcnt, bus.oferrcnt, bus.ofval, bus.ofabort} !== {4'd15, 4'd15, 2'b10} || bus.ofsymb !== 16'd10) begin
            bad++; $display("FAIL sat_eop oerrcnt=%0d oferrcnt=%0d ofval=%b ofabort=%b ofsymb=%0d exp=15 15 1 0 10",
                            bus.oerrcnt, bus.oferrcnt, bus.ofval, bus.ofabort, bus.ofsymb);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 4'b0000);
    endtask

    task automatic test_drop;
        drive(1'b1, 1'b0, 1'b0, 4'd8, 3'd5, 4'b0001);
        total++;
        if ({bus.oval, bus.odrop, bus.ofval} !== 3'b010 || bus.oerrcnt !== 4'd15 || bus.odat !== 3'd3) begin
            bad++; $display("FAIL drop_step flags=%b oerrcnt=%0d odat=%0d exp=010 15 3", {bus.oval, bus.odrop, bus.ofval}, bus.oerrcnt, bus.odat);
        end
        drive(1'b0, 1'b0, 1'b0, 4'd0, 3'd0, 4'b0000);
        total++;
        if (bus.odrop !== 1'b0) begin
            bad++; $display("FAIL drop_pulse odrop=%b exp=0", bus.odrop);
        end
        drive(1'b1, 1'b1, 1'b1, 4'd3, 3'd1, 4'b0010);
        total++;
        if ({bus.oval, bus.osop, bus.oeop, bus.ofval, bus.ofabort, bus.odrop} !== 6'b111100 || bus.otag !== 4'd3 || bus.ofsymb !== 16'd1 || bus.oferrcnt !== 4'd1) begin
            bad++; $display("FAIL drop_then_frame flags=%b otag=%0d ofsymb=%0d oferrcnt=%0d exp=111100 3 1 1",
                            {bus.oval, bus.osop, bus.oeop, bus.ofval, bus.ofabort, bus.odrop}, bus.otag, bus.ofsymb, bus.oferrcnt);
        end
    endtask

    task automatic test_clkena_reset;
        ena = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 4'b0000);
        total++;
        if ({bus.oval, bus.ofval, bus.oeop} !== 3'b111) begin
            bad++; $display("FAIL ena_strobe_hold got=%b exp=111", {bus.oval, bus.ofval, bus.oeop});
        end
        ena = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 4'd6, 3'd2, 4'b0001);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 3'd3, 4'b0011);
        ena = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 4'd0, 3'd7, 4'b1111);
        drive(1'b1, 1'b1, 1'b1, 4'd9, 3'd7, 4'b1111);
        total++;
        if ({bus.oval, bus.osop, bus.oeop, bus.ofval} !== 4'b1000 || {bus.oerrcnt, bus.obiterr, bus.odat, bus.otag} !== {4'd3, 3'd2, 3'd3, 4'd6}) begin
            bad++; $display("FAIL ena_freeze flags=%b oerrcnt=%0d obiterr=%0d odat=%0d otag=%0d exp=1000 3 2 3 6",
                            {bus.oval, bus.osop, bus.oeop, bus.ofval}, bus.oerrcnt, bus.obiterr, bus.odat, bus.otag);
        end
        ena = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 4'd0, 3'd4, 4'b0001);
        total++;
        if ({bus.oval, bus.oerrcnt, bus.odat, bus.ofval} !== {1'b1, 4'd4, 3'd4, 1'b0}) begin
            bad++; $display("FAIL ena_resume oval=%b oerrcnt=%0d odat=%0d ofval=%b exp=1 4 4 0", bus.oval, bus.oerrcnt, bus.odat, bus.ofval);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.oval, bus.osop, bus.oeop, bus.ofval, bus.ofabort, bus.odrop} !== 6'b0 ||
            {bus.otag, bus.odat, bus.obiterr, bus.oerrcnt, bus.ofsymb, bus.oferrcnt} !== '0) begin
            bad++; $display("FAIL async_reset oval=%b oerrcnt=%0d otag=%0d ofsymb=%0d exp=all zero", bus.oval, bus.oerrcnt, bus.otag, bus.ofsymb);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 4'd2, 3'd5, 4'b0011);
        total++;
        if ({bus.oval, bus.odrop, bus.ofval, bus.oerrcnt} !== {3'b010, 4'd0}) begin
            bad++; $display("FAIL post_reset_drop flags=%b oerrcnt=%0d exp=010 0", {bus.oval, bus.odrop, bus.ofval}, bus.oerrcnt);
        end
    endtask

    initial begin
        test_reset();
        test_frame8();
        test_single();
        test_abort();
        test_saturate();
        test_drop();
        test_clkena_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
